// File: rtl/serial_sub_nbit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_sub_nbit_if : start/ready/done handshake and operand/result bus   |
// | Rev 1.0 ; op exists only when SERIAL_SUB_ADD_MODE_EN is defined           |
// +--------------------------------------------------------------------------+
interface serial_sub_nbit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             op;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
`ifdef SERIAL_SUB_ADD_MODE_EN
    output op,
`endif
    output start, a, b, bin,
    input  ready, busy, done, diff, bout, ovf
  );

  modport slave (
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  op,
`endif
    input  start, a, b, bin,
    output ready, busy, done, diff, bout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_sub_nbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_sub_nbit : bit-serial ripple-borrow subtractor, one bit per clock  |
// | Rev 1.0 ; SERIAL_SUB_ADD_MODE_EN adds an op input selecting a + b + bin   |
// +--------------------------------------------------------------------------+
module serial_sub_nbit #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_nbit_if.slave  bus
);
  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             ak, bk, dk, br_nxt, ovf_bit;

  // Operands shift right, so bit 0 is always the bit under process; on the
  // last step it is the captured MSB, which the overflow term needs.
  always_comb begin
    ak = a_q[0];
    bk = b_q[0];
    dk = ak ^ bk ^ br_q;
    if (op_q) begin
      br_nxt  = (ak & bk) | (br_q & (ak ^ bk));
      ovf_bit = ~(ak ^ bk) & (ak ^ dk);
    end else begin
      br_nxt  = (~ak & bk) | (~(ak ^ bk) & br_q);
      ovf_bit = (ak ^ bk) & (ak ^ dk);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
          op_d    = bus.op;
`else
          op_d    = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nxt;
        diff_d = {dk, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          bout_d  = br_nxt;
          ovf_d   = ovf_bit;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_sub_nbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_sub_nbit : directed bench with expected-result queue            |
// | Rev 1.0 ; define SERIAL_SUB_ADD_MODE_EN to also exercise add mode         |
// +--------------------------------------------------------------------------+
module tb_serial_sub_nbit;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t last_exp;

  serial_sub_nbit_if #(.WIDTH(W)) bus_if ();

  serial_sub_nbit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Independent arithmetic model over plain integers.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, input logic op);
    exp_t e;
    int ua, ub, sa, sbv, u, r;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sbv = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (op) begin
      u      = ua + ub + int'(bin);
      r      = sa + sbv + int'(bin);
      e.bout = (u >= 2**W);
    end else begin
      u      = ua - ub - int'(bin);
      r      = sa - sbv - int'(bin);
      e.bout = (u < 0);
    end
    e.diff = W'(u);
    e.ovf  = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for IDLE, presents one operation and returns #1 after the accept edge.
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic op);
    int i;
    for (i = 0; i < 20 && bus_if.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.bin   = bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus_if.op    = op;
`endif
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(a, b, bin, op));
    bus_if.start = 1'b0;
    check({tag, "_ready_low"}, bus_if.ready, 1'b0);
  endtask

  // done must appear after exactly W edges past the accept edge, i.e. in the
  // (W+1)-th cycle counted from the accept cycle.
  task automatic wait_done(input string tag, input int already);
    int   edges;
    exp_t e;
    edges = 0;
    for (int i = already + 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        edges = i;
        break;
      end
    end
    check({tag, "_latency"}, edges, W);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_exp = e;
      check({tag, "_diff"}, bus_if.diff, e.diff);
      check({tag, "_bout"}, bus_if.bout, e.bout);
      check({tag, "_ovf"},  bus_if.ovf,  e.ovf);
      check({tag, "_busy_in_done"}, bus_if.busy, 1'b0);
    end
  endtask

  initial begin
    int dseen;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.bin   = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus_if.op    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus_if.ready, 1'b1);
    check("rst_busy",  bus_if.busy,  1'b0);
    check("rst_done",  bus_if.done,  1'b0);
    check("rst_diff",  bus_if.diff,  '0);
    check("rst_bout",  bus_if.bout,  1'b0);
    check("rst_ovf",   bus_if.ovf,   1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    start_op("op1", 4'b0101, 4'b0011, 1'b0, 1'b0);
    check("op1_busy", bus_if.busy, 1'b1);
    wait_done("op1", 0);
    start_op("op2", 4'b0000, 4'b0001, 1'b0, 1'b0);
    wait_done("op2", 0);
    start_op("op3", 4'b1111, 4'b1111, 1'b1, 1'b0);
    wait_done("op3", 0);
    start_op("op4", 4'b1000, 4'b0001, 1'b0, 1'b0);
    wait_done("op4", 0);
    start_op("op5", 4'b0111, 4'b1111, 1'b0, 1'b0);
    wait_done("op5", 0);

    // A start pulse during SHIFT must be ignored.
    start_op("ign", 4'b1010, 4'b0011, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.a     = 4'b1111;
    bus_if.b     = 4'b0000;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_done("ign", 3);
    check("ign_queue_empty", sb.size(), 0);

    // start held through DONE: accepted on the following IDLE cycle.
    bus_if.a     = 4'b0011;
    bus_if.b     = 4'b0101;
    bus_if.bin   = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    check("hold_idle_ready", bus_if.ready, 1'b1);
    check("hold_done_pulse", bus_if.done, 1'b0);
    check("hold_diff_stable", bus_if.diff, last_exp.diff);
    @(posedge clk); #1;
    check("hold_accept_busy", bus_if.busy, 1'b1);
    sb.push_back(model(4'b0011, 4'b0101, 1'b0, 1'b0));
    bus_if.start = 1'b0;
    wait_done("hold", 0);

    // Asynchronous reset two cycles into SHIFT.
    start_op("rstmid", 4'b1100, 4'b0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_ready", bus_if.ready, 1'b1);
    check("rstmid_busy",  bus_if.busy,  1'b0);
    check("rstmid_done",  bus_if.done,  1'b0);
    check("rstmid_diff",  bus_if.diff,  '0);
    check("rstmid_bout",  bus_if.bout,  1'b0);
    check("rstmid_ovf",   bus_if.ovf,   1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    dseen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) dseen++;
    end
    check("rstmid_no_done", dseen, 0);
    start_op("post_rst", 4'b0110, 4'b0100, 1'b1, 1'b0);
    wait_done("post_rst", 0);

`ifdef SERIAL_SUB_ADD_MODE_EN
    start_op("add1", 4'b1111, 4'b0001, 1'b1, 1'b1);
    wait_done("add1", 0);
    start_op("add2", 4'b0100, 4'b0100, 1'b0, 1'b1);
    wait_done("add2", 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/serial_sub_nbit.md
Name: serial_sub_nbit

Overview:
- Bit-serial N-bit ripple-borrow subtractor, the inverse-direction companion to the team's N-bit ripple-carry adder.
- Computes diff = a - b - bin one bit per clock through a single 1-bit full-subtractor slice and a borrow flip-flop.
- Uses a start/ready/done handshake.
- Used where area matters more than latency, and as a reference model for adder/subtractor cross-checks.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT only.
- done  output  1  one-cycle pulse when result becomes valid.
- diff  output  WIDTH  result; holds until the next accepted start.
- bout  output  1  final borrow-out (unsigned a < b+bin).
- ovf  output  1  signed overflow of the two's-complement difference.

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - state=IDLE; ready=1; busy=0; done=0.
  - diff=0; bout=0; ovf=0; internal shift regs, borrow FF and bit counter all 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: ready=1. Edge with start=1 loads a, b into shift regs, borrow FF <= bin, count <= 0, state -> SHIFT. With start=0, stay in IDLE.
  - SHIFT: busy=1, ready=0. Each edge processes bit k=count, LSB first:
    - d_k = a_k ^ b_k ^ br
    - br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br)
    - d_k is shifted into the diff register from the MSB end; count increments.
    - On the edge processing k=WIDTH-1: state -> DONE; bout <= br_next; ovf <= (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1]), using the captured a and b.
  - DONE: done=1 for exactly this one cycle; ready=0; busy=0. Next edge -> IDLE.
- Latency:
  - start accepted at edge E0.
  - SHIFT occupies edges E1..E(WIDTH) (count 0..WIDTH-1 processed).
  - done is high in the cycle following edge E(WIDTH); diff/bout/ovf are valid from that same cycle.
  - Throughput: one operation per WIDTH+2 cycles.
- diff is visible as a partial value during SHIFT and is not qualified. Consumers sample only on done or later.
- start while ready=0 (SHIFT or DONE): ignored, no queuing; operand inputs ignored.
- start held high continuously: a new operation is accepted on each IDLE cycle. Back-to-back ops are therefore separated by one IDLE cycle.
- Input changes on a, b, bin after acceptance have no effect on the operation in flight.
- Arithmetic is modulo 2^WIDTH. bout=1 iff {1'b0,a} < {1'b0,b} + bin.
- Counter width is clog2(WIDTH); no wrap-around is reachable because SHIFT exits at count=WIDTH-1.
- rst asserted mid-SHIFT or in DONE: immediate return to reset values, and the done pulse is suppressed. The first start after reset deassertion is accepted normally.

Optional Feature:
- Macro SERIAL_SUB_ADD_MODE_EN.
- Defined:
  - Extra input port op (1 bit), captured with the operands on an accepted start. op=0 subtract, as above; op=1 add: diff = a + b + bin.
  - Add mode uses the carry equations s = a^b^c and c_next = ab | c(a^b). bout reports carry-out.
  - In add mode, ovf = ~(a[W-1]^b[W-1]) & (a[W-1]^s[W-1]).
- Not defined: no op port; subtract only.

Test Plan:
- Reset, then a=4'b0101, b=4'b0011, bin=0, start one cycle -> ready=0 next cycle; done high exactly 5 cycles after the accept edge (WIDTH+1); diff=4'b0010, bout=0, ovf=0.
- a=4'b0000, b=4'b0001, bin=0 -> diff=4'b1111, bout=1, ovf=0. Then a=4'b1111, b=4'b1111, bin=1 -> diff=4'b1111, bout=1, ovf=0.
- a=4'b1000, b=4'b0001, bin=0 -> diff=4'b0111, bout=0, ovf=1. Then a=4'b0111, b=4'b1111, bin=0 -> diff=4'b1000, bout=1, ovf=1.
- Pulse start again during SHIFT with a=4'b1111, b=0 -> ignored; result still from the first operands. Hold start high -> a second operation accepted in the IDLE cycle after done; diff stable between done and the next done.
- Assert rst 2 cycles into SHIFT -> all outputs 0 and ready=1 immediately (asynchronous), no done pulse. Next op a=4'b0110, b=4'b0100, bin=1 -> diff=4'b0001, bout=0.
- With SERIAL_SUB_ADD_MODE_EN: op=1, a=4'b1111, b=4'b0001, bin=1 -> diff=4'b0001, bout=1, ovf=0. op=1, a=4'b0100, b=4'b0100, bin=0 -> diff=4'b1000, bout=0, ovf=1.
